lsu_mem_bridge: RTL and testbench
=================================

Name: lsu_mem_bridge

Overview:
- Load/store bridge between the hart's data-access path and a realistic variable-latency data memory.
- Accepts one byte-addressed load/store request at a time and derives the word-aligned address, byte mask and lane-shifted write data.
- Runs a ready/valid handshake with memory, then returns a sign/zero-extended load result or a trap.
- Replaces the combinational dmem model; the hart stalls on o_req_ready / o_rsp_valid.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before the request is abandoned with a timeout trap; legal range 1..65535.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  hart presents a request.
- o_req_ready  out  1  bridge accepts a request; high only in IDLE.
- i_req_wen  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-justified.
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_req_unsigned  in  1  zero-extend the load result (lbu/lhu).
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores and traps.
- o_rsp_trap  out  1  misaligned, illegal size, or timeout.
- o_rsp_timeout  out  1  the trap was caused by timeout.
- o_mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- o_mem_ren  out  1  read request.
- o_mem_wen  out  1  write request; never high together with o_mem_ren.
- o_mem_wdata  out  32  lane-shifted store data.
- o_mem_mask  out  4  byte-lane enables.
- i_mem_ready  in  1  memory accepts the request this cycle.
- i_mem_valid  in  1  read data valid / write acknowledged.
- i_mem_rdata  in  32  read word.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset state: IDLE. All outputs 0 except o_req_ready=1.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, capture all request fields.
  - Misaligned or illegal request (half with addr[0]=1; word with addr[1:0]!=0; size 11) -> RESP with trap=1; no memory access.
  - Otherwise -> ISSUE.
- ISSUE:
  - o_mem_ren/o_mem_wen and o_mem_addr/wdata/mask are driven from registers and held stable until i_mem_ready.
  - i_mem_ready & i_mem_valid in the same cycle -> capture, go to RESP.
  - i_mem_ready alone -> WAIT, deassert ren/wen.
- WAIT:
  - A 16-bit counter starts at 0 and increments each cycle.
  - i_mem_valid -> capture i_mem_rdata, go to RESP.
  - Counter reaching TIMEOUT_CYCLES-1 without valid -> RESP with trap=1, timeout=1.
  - The ISSUE cycles spent waiting for i_mem_ready are not counted.
- RESP:
  - o_rsp_valid=1 for exactly one cycle, then IDLE.
  - o_rsp_* hold their values only during RESP and are 0 otherwise.
- i_mem_valid in IDLE or RESP is ignored: a late response is dropped.
- Minimum latency: accept at cycle N, memory request at N+1, response at N+2 with zero-latency memory.
- Lane rules (off = addr[1:0]):
  - Mask: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
  - o_mem_wdata = wdata << (8*off).
  - Load: shifted = rdata >> (8*off); byte extends bit 7, half extends bit 15; i_req_unsigned forces zero-extension.
  - For word loads, unsigned is ignored.
- Stores: o_rsp_rdata=0; response is raised on the write acknowledge (i_mem_valid).
- Reset mid-operation: next cycle is IDLE, ren/wen low, counter cleared; any outstanding response is discarded.
- Back-to-back requests: a new request is accepted only in IDLE, so one bubble (the RESP cycle) separates requests.

Decomposition:
- Shared package (lsu_pkg):
  - size encodings SIZE_B/H/W.
  - FSM state localparams.
  - Misalignment check as a function.
- One combinational sub-module, lsu_lane_align:
  - inputs: off, size, unsigned, wdata, rdata.
  - outputs: mask, shifted wdata, extended rdata.
  - Reused later by a pipelined MEM stage.
- FSM, capture registers and timeout counter live in lsu_mem_bridge.

Test Plan:
- lb from addr 0x1003, memory returns 0x80_11_22_33 with ready=valid=1 the cycle after acceptance -> mem_addr 0x1000, mask 1000, response 2 cycles after accept, rdata 0xFFFFFF80; the same load with i_req_unsigned=1 -> 0x00000080.
- sh data 0x0000ABCD to 0x2002, ready delayed 3 cycles, valid 2 cycles later -> wen held stable 4 cycles, mask 1100, wdata 0xABCD0000, one rsp_valid with rdata 0.
- lw at 0x3001, lh at 0x3003, and size=11 -> rsp_trap=1 one cycle after accept; ren/wen never asserted.
- TIMEOUT_CYCLES=8, ready given, valid withheld -> rsp_valid with trap=1 and timeout=1 exactly 8 cycles after entering WAIT; a subsequent stray i_mem_valid is ignored.
- i_rst asserted while in WAIT -> next cycle IDLE, o_req_ready=1, ren=0; a late i_mem_valid produces no response.
- Back-to-back lw 0x10 and lw 0x14 with zero-latency memory -> responses 3 cycles apart; o_req_ready low during ISSUE/RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory bridge and its lane-align helper.
// Size encodings, FSM state type and the access legality check.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // True when the access must trap without touching memory.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_bridge_if.sv
// Hart-side request/response bundle and memory-side bus bundle.
// Signal prefixes are from the bridge's point of view.
interface lsu_req_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wen;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_trap;
    logic        o_rsp_timeout;

    modport master (
        output i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap, o_rsp_timeout
    );
    modport slave (
        input  i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap, o_rsp_timeout
    );
endinterface

interface lsu_mem_if;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    modport master (
        output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
        input  i_mem_ready, i_mem_valid, i_mem_rdata
    );
    modport slave (
        input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
        output i_mem_ready, i_mem_valid, i_mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask/data shift and load shift with sign/zero extension.
// Purely combinational so a pipelined MEM stage can reuse it unchanged.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;

    assign w_shamt   = {i_off, 3'b000};
    assign w_shifted = i_rdata >> w_shamt;
    assign o_wdata   = i_wdata << w_shamt;

    always_comb begin
        o_mask  = 4'b1111;
        o_rdata = w_shifted;
        case (i_size)
            SIZE_B: begin
                o_mask  = 4'b0001 << i_off;
                o_rdata = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
            end
            SIZE_H: begin
                o_mask  = 4'b0011 << i_off;
                o_rdata = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
            end
            default: begin
                o_mask  = 4'b1111;
                o_rdata = w_shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Single-outstanding load/store bridge from the hart to a variable-latency data memory.
// state | meaning
// IDLE  | ready for a request; illegal/misaligned requests go straight to RESP
// ISSUE | ren/wen held with addr/data/mask until memory accepts
// WAIT  | accepted, waiting for data/ack; counts toward the timeout
// RESP  | one-cycle response pulse, then back to IDLE
module lsu_mem_bridge
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic      i_clk,
    input  logic      i_rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e  r_state;
    logic        r_req_ready;
    logic        r_wen;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [15:0] r_cnt;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_trap;
    logic        r_rsp_timeout;
    logic [31:0] r_mem_addr;
    logic        r_mem_ren;
    logic        r_mem_wen;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_mask;

    logic [1:0]  w_off;
    logic [1:0]  w_size;
    logic        w_unsigned;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

    // In IDLE the aligner works on the incoming request (store side);
    // afterwards it works on the captured request (load return side).
    assign w_off      = (r_state == ST_IDLE) ? req.i_req_addr[1:0] : r_off;
    assign w_size     = (r_state == ST_IDLE) ? req.i_req_size      : r_size;
    assign w_unsigned = (r_state == ST_IDLE) ? req.i_req_unsigned  : r_unsigned;

    lsu_lane_align u_align (
        .i_off      (w_off),
        .i_size     (w_size),
        .i_unsigned (w_unsigned),
        .i_wdata    (req.i_req_wdata),
        .i_rdata    (mem.i_mem_rdata),
        .o_mask     (w_mask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_wen         <= 1'b0;
            r_off         <= 2'b00;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_trap    <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_ren     <= 1'b0;
            r_mem_wen     <= 1'b0;
            r_mem_wdata   <= '0;
            r_mem_mask    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req.i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_wen       <= req.i_req_wen;
                        r_off       <= req.i_req_addr[1:0];
                        r_size      <= req.i_req_size;
                        r_unsigned  <= req.i_req_unsigned;
                        r_mem_addr  <= {req.i_req_addr[31:2], 2'b00};
                        r_mem_wdata <= w_wdata;
                        r_mem_mask  <= w_mask;
                        if (is_bad_access(req.i_req_size, req.i_req_addr[1:0])) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_trap  <= 1'b1;
                        end else begin
                            r_state   <= ST_ISSUE;
                            r_mem_ren <= ~req.i_req_wen;
                            r_mem_wen <= req.i_req_wen;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem.i_mem_ready) begin
                        r_mem_ren <= 1'b0;
                        r_mem_wen <= 1'b0;
                        if (mem.i_mem_valid) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= r_wen ? '0 : w_rdata;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem.i_mem_valid) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_wen ? '0 : w_rdata;
                    end else if (r_cnt == TO_LAST) begin
                        r_state       <= ST_RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_trap    <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    r_state       <= ST_IDLE;
                    r_req_ready   <= 1'b1;
                    r_rsp_valid   <= 1'b0;
                    r_rsp_rdata   <= '0;
                    r_rsp_trap    <= 1'b0;
                    r_rsp_timeout <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req.o_req_ready   = r_req_ready;
    assign req.o_rsp_valid   = r_rsp_valid;
    assign req.o_rsp_rdata   = r_rsp_rdata;
    assign req.o_rsp_trap    = r_rsp_trap;
    assign req.o_rsp_timeout = r_rsp_timeout;
    assign mem.o_mem_addr    = r_mem_addr;
    assign mem.o_mem_ren     = r_mem_ren;
    assign mem.o_mem_wen     = r_mem_wen;
    assign mem.o_mem_wdata   = r_mem_wdata;
    assign mem.o_mem_mask    = r_mem_mask;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Self-checking bench for lsu_mem_bridge: directed vector table, corner sequences,
// and random transactions checked against a byte-level reference model.
module tb_lsu_mem_bridge;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_req_if req_if ();
    lsu_mem_if mem_if ();

    lsu_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .req   (req_if),
        .mem   (mem_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        int          rdly;   // ISSUE cycles before mem ready
        int          vdly;   // 0: valid with ready; k: valid in WAIT cycle k-1
        logic [31:0] word;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_trap;
        logic        e_to;
    } txn_t;

    txn_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns, input int rdly, input int vdly,
                                input logic [31:0] word, input logic [31:0] e_addr, input logic [3:0] e_mask,
                                input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                                input logic e_trap, input logic e_to);
        txn_t t;
        t.wen = wen; t.addr = addr; t.wdata = wdata; t.size = size; t.uns = uns;
        t.rdly = rdly; t.vdly = vdly; t.word = word; t.e_addr = e_addr; t.e_mask = e_mask;
        t.e_wdata = e_wdata; t.e_rdata = e_rdata; t.e_trap = e_trap; t.e_to = e_to;
        return t;
    endfunction

    // Reference model: byte-by-byte view of the access, independent of shift/mask logic.
    function automatic txn_t model(input txn_t t);
        txn_t   r;
        int     off;
        int     nb;
        longint v;
        r   = t;
        off = int'(t.addr % 4);
        nb  = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : (t.size == 2'd2) ? 4 : 0;
        r.e_addr  = t.addr - 32'(off);
        r.e_wdata = t.wdata << (8 * off);
        r.e_mask  = '0;
        r.e_rdata = '0;
        r.e_to    = 1'b0;
        r.e_trap  = (nb == 0) ? 1'b1 : ((off % nb) != 0);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nb) r.e_mask[i] = 1'b1;
        if (!r.e_trap && t.vdly > TO) begin
            r.e_trap = 1'b1;
            r.e_to   = 1'b1;
        end else if (!r.e_trap && !t.wen) begin
            v = 0;
            for (int i = 0; i < nb; i++)
                v += longint'((t.word >> (8 * (off + i))) & 32'hFF) << (8 * i);
            if (!t.uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v -= longint'(1) << (8 * nb);
            r.e_rdata = v[31:0];
        end
        return r;
    endfunction

    // Starts in IDLE just after a clock edge; plays the memory and checks the response.
    task automatic run_txn(input txn_t t, input string tag);
        int cyc, ik, wk, exp_lat;
        bit in_issue, got;
        if (t.e_trap && !t.e_to) exp_lat = 1;
        else exp_lat = 1 + t.rdly + ((t.vdly == 0) ? 1 : (t.e_to ? TO + 1 : t.vdly + 1));
        chk({tag, "_idle_ready"}, 32'(req_if.o_req_ready), 32'd1);
        req_if.i_req_valid    = 1'b1;
        req_if.i_req_wen      = t.wen;
        req_if.i_req_addr     = t.addr;
        req_if.i_req_wdata    = t.wdata;
        req_if.i_req_size     = t.size;
        req_if.i_req_unsigned = t.uns;
        step;
        req_if.i_req_valid = 1'b0;
        req_if.i_req_addr  = $urandom;
        req_if.i_req_wdata = $urandom;
        cyc = 1; ik = 0; wk = 0; in_issue = 1'b1; got = 1'b0;
        while (cyc < 48) begin
            if (req_if.o_rsp_valid) begin
                chk({tag, "_rsp_no_mem"}, 32'({mem_if.o_mem_ren, mem_if.o_mem_wen}), 32'd0);
                got = 1'b1;
                break;
            end
            mem_if.i_mem_ready = 1'b0;
            mem_if.i_mem_valid = 1'b0;
            mem_if.i_mem_rdata = $urandom;
            if (in_issue) begin
                chk({tag, "_issue_ren"},   32'(mem_if.o_mem_ren), 32'(!t.wen));
                chk({tag, "_issue_wen"},   32'(mem_if.o_mem_wen), 32'(t.wen));
                chk({tag, "_issue_addr"},  mem_if.o_mem_addr, t.e_addr);
                chk({tag, "_issue_mask"},  32'(mem_if.o_mem_mask), 32'(t.e_mask));
                chk({tag, "_issue_wdata"}, mem_if.o_mem_wdata, t.e_wdata);
                chk({tag, "_issue_nready"}, 32'(req_if.o_req_ready), 32'd0);
                if (ik == t.rdly) begin
                    mem_if.i_mem_ready = 1'b1;
                    in_issue = 1'b0;
                    if (t.vdly == 0) begin
                        mem_if.i_mem_valid = 1'b1;
                        mem_if.i_mem_rdata = t.word;
                    end
                end
                ik++;
            end else begin
                chk({tag, "_wait_idle_bus"}, 32'({mem_if.o_mem_ren, mem_if.o_mem_wen}), 32'd0);
                if (wk == t.vdly - 1) begin
                    mem_if.i_mem_valid = 1'b1;
                    mem_if.i_mem_rdata = t.word;
                end
                wk++;
            end
            step;
            cyc++;
        end
        mem_if.i_mem_ready = 1'b0;
        mem_if.i_mem_valid = 1'b0;
        chk({tag, "_rsp_seen"},    32'(got), 32'd1);
        chk({tag, "_rsp_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_rsp_rdata"},   req_if.o_rsp_rdata, t.e_rdata);
        chk({tag, "_rsp_trap"},    32'(req_if.o_rsp_trap), 32'(t.e_trap));
        chk({tag, "_rsp_timeout"}, 32'(req_if.o_rsp_timeout), 32'(t.e_to));
        step;
        chk({tag, "_rsp_pulse"}, 32'({req_if.o_rsp_valid, req_if.o_rsp_trap, req_if.o_rsp_timeout}), 32'd0);
        chk({tag, "_rsp_rdata_clr"}, req_if.o_rsp_rdata, 32'd0);
        chk({tag, "_back_ready"}, 32'(req_if.o_req_ready), 32'd1);
    endtask

    initial begin
        txn_t t;
        tbl[0]  = mk(0, 32'h1003, 32'h0,        2'b00, 0, 0, 0,   32'h80112233, 32'h1000, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0);
        tbl[1]  = mk(0, 32'h1003, 32'h0,        2'b00, 1, 0, 0,   32'h80112233, 32'h1000, 4'b1000, 32'h0,        32'h00000080, 0, 0);
        tbl[2]  = mk(1, 32'h2002, 32'h0000ABCD, 2'b01, 0, 3, 2,   32'hFFFFFFFF, 32'h2000, 4'b1100, 32'hABCD0000, 32'h0,        0, 0);
        tbl[3]  = mk(0, 32'h3001, 32'h0,        2'b10, 0, 0, 0,   32'h0,        32'h3000, 4'b0000, 32'h0,        32'h0,        1, 0);
        tbl[4]  = mk(0, 32'h3003, 32'h0,        2'b01, 0, 0, 0,   32'h0,        32'h3000, 4'b0000, 32'h0,        32'h0,        1, 0);
        tbl[5]  = mk(1, 32'h3000, 32'h0,        2'b11, 0, 0, 0,   32'h0,        32'h3000, 4'b0000, 32'h0,        32'h0,        1, 0);
        tbl[6]  = mk(0, 32'h4000, 32'h0,        2'b10, 0, 1, 255, 32'h0,        32'h4000, 4'b1111, 32'h0,        32'h0,        1, 1);
        tbl[7]  = mk(0, 32'h5002, 32'h0,        2'b01, 0, 0, 1,   32'h80017FFF, 32'h5000, 4'b1100, 32'h0,        32'hFFFF8001, 0, 0);
        tbl[8]  = mk(0, 32'h5002, 32'h0,        2'b01, 1, 1, 0,   32'h80017FFF, 32'h5000, 4'b1100, 32'h0,        32'h00008001, 0, 0);
        tbl[9]  = mk(0, 32'h6000, 32'h0,        2'b10, 1, 2, 1,   32'hDEADBEEF, 32'h6000, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0);
        tbl[10] = mk(1, 32'h7001, 32'h000000A5, 2'b00, 0, 1, 0,   32'h0,        32'h7000, 4'b0010, 32'h0000A500, 32'h0,        0, 0);
        tbl[11] = mk(0, 32'h8002, 32'h0,        2'b00, 0, 0, 8,   32'h007F0000, 32'h8000, 4'b0100, 32'h0,        32'h0000007F, 0, 0);
        tbl[12] = mk(1, 32'h9000, 32'h12345678, 2'b10, 0, 2, 9,   32'h0,        32'h9000, 4'b1111, 32'h12345678, 32'h0,        1, 1);
        tbl[13] = mk(1, 32'h700B, 32'hFFFFFF5A, 2'b00, 0, 0, 3,   32'h0,        32'h7008, 4'b1000, 32'h5A000000, 32'h0,        0, 0);

        req_if.i_req_valid = 1'b0; req_if.i_req_wen = 1'b0; req_if.i_req_addr = '0;
        req_if.i_req_wdata = '0;   req_if.i_req_size = 2'b00; req_if.i_req_unsigned = 1'b0;
        mem_if.i_mem_ready = 1'b0; mem_if.i_mem_valid = 1'b0; mem_if.i_mem_rdata = '0;

        rst = 1'b1;
        step; step;
        chk("reset_ready", 32'(req_if.o_req_ready), 32'd1);
        chk("reset_rsp", 32'({req_if.o_rsp_valid, req_if.o_rsp_trap, req_if.o_rsp_timeout}), 32'd0);
        chk("reset_rdata", req_if.o_rsp_rdata, 32'd0);
        chk("reset_bus", 32'({mem_if.o_mem_ren, mem_if.o_mem_wen, mem_if.o_mem_mask}), 32'd0);
        chk("reset_addr", mem_if.o_mem_addr, 32'd0);
        chk("reset_wdata", mem_if.o_mem_wdata, 32'd0);
        rst = 1'b0;
        step;

        for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Stray memory valid after a timed-out request must be dropped.
        run_txn(tbl[6], "to_then_stray");
        mem_if.i_mem_valid = 1'b1;
        mem_if.i_mem_rdata = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            step;
            chk("stray_no_rsp", 32'(req_if.o_rsp_valid), 32'd0);
            chk("stray_ready", 32'(req_if.o_req_ready), 32'd1);
        end
        mem_if.i_mem_valid = 1'b0;

        // Reset while waiting in WAIT.
        req_if.i_req_valid = 1'b1; req_if.i_req_wen = 1'b0; req_if.i_req_addr = 32'h100;
        req_if.i_req_size = 2'b10; req_if.i_req_unsigned = 1'b0;
        step;
        req_if.i_req_valid = 1'b0;
        chk("rstw_ren_issue", 32'(mem_if.o_mem_ren), 32'd1);
        mem_if.i_mem_ready = 1'b1;
        step;
        mem_if.i_mem_ready = 1'b0;
        step; step;
        chk("rstw_in_wait", 32'({req_if.o_req_ready, mem_if.o_mem_ren, req_if.o_rsp_valid}), 32'd0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("rstw_ready", 32'(req_if.o_req_ready), 32'd1);
        chk("rstw_ren", 32'(mem_if.o_mem_ren), 32'd0);
        chk("rstw_rsp", 32'(req_if.o_rsp_valid), 32'd0);
        mem_if.i_mem_valid = 1'b1;
        mem_if.i_mem_rdata = 32'h55AA55AA;
        step;
        mem_if.i_mem_valid = 1'b0;
        chk("rstw_late_valid", 32'(req_if.o_rsp_valid), 32'd0);
        step;
        chk("rstw_late_valid2", 32'(req_if.o_rsp_valid), 32'd0);
        run_txn(tbl[6], "rstw_timeout_after");

        // Back-to-back word loads, zero-latency memory; hart holds valid high.
        req_if.i_req_valid = 1'b1; req_if.i_req_wen = 1'b0; req_if.i_req_addr = 32'h10;
        req_if.i_req_size = 2'b10; req_if.i_req_unsigned = 1'b0;
        step;
        chk("b2b_ready_issue1", 32'(req_if.o_req_ready), 32'd0);
        chk("b2b_addr1", mem_if.o_mem_addr, 32'h10);
        req_if.i_req_addr = 32'h14;
        mem_if.i_mem_ready = 1'b1; mem_if.i_mem_valid = 1'b1; mem_if.i_mem_rdata = 32'hA1A2A3A4;
        step;
        mem_if.i_mem_ready = 1'b0; mem_if.i_mem_valid = 1'b0;
        chk("b2b_rsp1", 32'(req_if.o_rsp_valid), 32'd1);
        chk("b2b_rdata1", req_if.o_rsp_rdata, 32'hA1A2A3A4);
        chk("b2b_ready_resp", 32'(req_if.o_req_ready), 32'd0);
        step;
        chk("b2b_gap_rsp", 32'(req_if.o_rsp_valid), 32'd0);
        chk("b2b_gap_ready", 32'(req_if.o_req_ready), 32'd1);
        step;
        req_if.i_req_valid = 1'b0;
        chk("b2b_addr2", mem_if.o_mem_addr, 32'h14);
        chk("b2b_ren2", 32'(mem_if.o_mem_ren), 32'd1);
        mem_if.i_mem_ready = 1'b1; mem_if.i_mem_valid = 1'b1; mem_if.i_mem_rdata = 32'hB1B2B3B4;
        step;
        mem_if.i_mem_ready = 1'b0; mem_if.i_mem_valid = 1'b0;
        chk("b2b_rsp2", 32'(req_if.o_rsp_valid), 32'd1);
        chk("b2b_rdata2", req_if.o_rsp_rdata, 32'hB1B2B3B4);
        step;
        chk("b2b_end_ready", 32'(req_if.o_req_ready), 32'd1);

        // Random transactions against the reference model.
        for (int n = 0; n < 200; n++) begin
            int r;
            t.wen   = 1'($urandom);
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.size  = 2'($urandom_range(0, 3));
            t.uns   = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                if (t.size == 2'b01) t.addr[0] = 1'b0;
                if (t.size == 2'b10) t.addr[1:0] = 2'b00;
            end
            t.rdly = $urandom_range(0, 3);
            r      = $urandom_range(0, 11);
            t.vdly = (r == 11) ? 255 : r;
            t.word = $urandom;
            t = model(t);
            run_txn(t, "rnd");
            r = $urandom_range(0, 2);
            for (int g = 0; g < r; g++) begin
                mem_if.i_mem_valid = 1'($urandom);
                mem_if.i_mem_rdata = $urandom;
                step;
                chk("rnd_gap_no_rsp", 32'(req_if.o_rsp_valid), 32'd0);
            end
            mem_if.i_mem_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
